prog_run_ctrl: RTL

- Parametrised run controller between the bench start/done handshake and the single-cycle core.
- Replaces the fixed "reset while start low, done when pc==FF" scheme with an explicit FSM:
  - program slot selection (start PC);
  - programmable core-reset stretch;
  - configurable halt PC;
  - run-cycle counter;
  - watchdog timeout and abort.
- Sits at top level; drives core reset and start PC; observes core PC.

---
 rtl/prog_run_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/prog_run_ctrl.sv
// Run controller between the start/done handshake and the single-cycle core:
// slot select, core-reset stretch, halt detection, run-cycle counter, watchdog, abort.
module prog_run_ctrl #(
  parameter int                PC_W        = 8,
  parameter logic [PC_W-1:0]   HALT_PC     = '1,
  parameter int                NUM_PROGS   = 3,
  parameter int                SEL_W       = 2,
  parameter int                PROG_STRIDE = 64,
  parameter int                RST_CYCLES  = 2,
  parameter int                CYC_W       = 16,
  parameter int                TIMEOUT     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [SEL_W-1:0] prog_sel,
  input  logic [PC_W-1:0]  core_pc,
  output logic             core_rst,
  output logic [PC_W-1:0]  start_pc,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             bad_sel,
  output logic [CYC_W-1:0] cycle_count
);

  localparam int               RST_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);
  localparam logic [31:0]      NP_C  = 32'(NUM_PROGS);
  localparam logic [CYC_W-1:0] TO_C  = CYC_W'(TIMEOUT);
  localparam logic [RST_W-1:0] RST_C = RST_W'(RST_CYCLES);

  typedef enum logic [1:0] {IDLE, CORE_RST, RUN, DONE} state_t;

  state_t           r_state;
  logic             r_start_q;
  logic             r_arm;
  logic [RST_W-1:0] r_rcnt;
  logic             r_core_rst, r_busy, r_done, r_timeout, r_bad_sel;
  logic [PC_W-1:0]  r_start_pc;
  logic [CYC_W-1:0] r_cyc;

  logic             w_edge, w_sel_ok, w_halt, w_to;
  logic [PC_W-1:0]  w_base;
  logic [CYC_W-1:0] w_cyc_inc;

  // r_arm masks the first cycle after reset so a start held across release is not an edge
  assign w_edge    = start & ~r_start_q & r_arm;
  assign w_sel_ok  = 32'(prog_sel) < NP_C;
  assign w_base    = PC_W'(32'(prog_sel) * 32'(PROG_STRIDE));
  assign w_cyc_inc = (r_cyc == '1) ? r_cyc : r_cyc + 1'b1;
  assign w_halt    = (core_pc == HALT_PC);
  assign w_to      = (TIMEOUT != 0) && (w_cyc_inc == TO_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_start_q  <= 1'b0;
      r_arm      <= 1'b0;
      r_rcnt     <= '0;
      r_core_rst <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_bad_sel  <= 1'b0;
      r_start_pc <= '0;
      r_cyc      <= '0;
    end else begin
      r_start_q <= start;
      r_arm     <= 1'b1;
      case (r_state)
        IDLE, DONE: begin
          if (w_edge) begin
            if (w_sel_ok) begin
              r_state    <= CORE_RST;
              r_start_pc <= w_base;
              r_done     <= 1'b0;
              r_timeout  <= 1'b0;
              r_bad_sel  <= 1'b0;
              r_cyc      <= '0;
              r_rcnt     <= RST_C;
              r_busy     <= 1'b1;
              r_core_rst <= 1'b1;
            end else begin
              r_bad_sel  <= 1'b1;
            end
          end
        end
        CORE_RST: begin
          if (abort) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_core_rst <= 1'b1;
          end else if (r_rcnt <= RST_W'(1)) begin
            r_state    <= RUN;
            r_core_rst <= 1'b0;
          end else begin
            r_rcnt     <= r_rcnt - 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_core_rst <= 1'b1;
          end else begin
            r_cyc <= w_cyc_inc;
            // halt outranks the watchdog on a shared edge
            if (w_halt || w_to) begin
              r_state    <= DONE;
              r_done     <= 1'b1;
              r_timeout  <= ~w_halt;
              r_busy     <= 1'b0;
              r_core_rst <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign core_rst    = r_core_rst;
  assign start_pc    = r_start_pc;
  assign busy        = r_busy;
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign bad_sel     = r_bad_sel;
  assign cycle_count = r_cyc;

endmodule
